// File: rtl/led_uart_pkg.sv
// led_uart_pkg: opcodes, reply bytes, timeout length and frame FSM states shared by led_uart_ctrl
package led_uart_pkg;
  localparam logic [3:0] OP_SET_CH = 4'hA;
  localparam logic [3:0] OP_SET_ALL = 4'hB;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int TIMEOUT_BITS = 32;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, COMMIT} frame_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-FF synchroniser, start-bit glitch reject and stop-bit framing check
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic busy, rx_s, fall;
  // sync[1] is the synchronised line, sync[2] its previous value for edge detect
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      data_byte <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      valid <= 1'b0;
      frame_err <= 1'b0;
      if (!busy) begin
        busy <= fall;
        cnt <= '0;
        idx <= '0;
      end else if (cnt != (idx == 4'd0 ? HALF : FULL)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        idx <= idx + 4'd1;
        if (idx == 4'd0) busy <= ~rx_s;
        else if (idx != 4'd9) data_byte <= {rx_s, data_byte[7:1]};
        else begin
          busy <= 1'b0;
          valid <= rx_s;
          frame_err <= ~rx_s;
        end
      end
    end
  end
endmodule

// File: rtl/led_uart_ctrl.sv
// led_uart_ctrl: UART-commanded NUM_CH PWM LED driver; ACK/NAK replies on uart_tx when LED_UART_ACK_EN is defined
module led_uart_ctrl import led_uart_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int PWM_W = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk_12p0,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic [NUM_CH-1:0] led,
  output logic [7:0]        err_cnt
);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYC);
  logic [7:0] rx_byte, data;
  logic rx_valid, rx_err, cmd_ok, timeout, err_event, tgt_all;
  logic [3:0] tgt_ch;
  logic [TW-1:0] to_cnt;
  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] shadow [NUM_CH];
  logic [PWM_W-1:0] duty [NUM_CH];
  frame_state_t state, state_nx;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk_12p0),
    .rst(rst),
    .rx(uart_rx),
    .data_byte(rx_byte),
    .valid(rx_valid),
    .frame_err(rx_err)
  );
  assign cmd_ok = (rx_byte[7:4] == OP_SET_CH && int'(rx_byte[3:0]) < NUM_CH) || rx_byte[7:4] == OP_SET_ALL;
  assign timeout = to_cnt == TW'(TO_CYC - 1);
  // a byte arriving on the timeout cycle still completes the frame
  always_comb begin
    state_nx = state;
    err_event = rx_err;
    unique case (state)
      IDLE: if (rx_valid) begin
        state_nx = cmd_ok ? WAIT_DATA : IDLE;
        err_event = !cmd_ok;
      end
      WAIT_DATA: if (rx_valid) state_nx = COMMIT;
      else if (rx_err || timeout) begin
        state_nx = IDLE;
        err_event = 1'b1;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_12p0 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err_cnt <= '0;
      to_cnt <= '0;
      tgt_all <= 1'b0;
      tgt_ch <= '0;
      data <= '0;
    end else begin
      state <= state_nx;
      if (err_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      to_cnt <= state == WAIT_DATA ? to_cnt + 1'b1 : '0;
      if (state == IDLE && rx_valid) begin
        tgt_all <= rx_byte[7:4] == OP_SET_ALL;
        tgt_ch <= rx_byte[3:0];
      end
      if (rx_valid) data <= rx_byte;
    end
  end
  // shadow duties latch in COMMIT; active duties only move on the counter wrap
  always_ff @(posedge clk_12p0 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        duty[i] <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == COMMIT && (tgt_all || int'(tgt_ch) == i)) shadow[i] <= data[7 -: PWM_W];
        if (&cnt) duty[i] <= shadow[i];
      end
    end
  end
  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_CH; i++) led[i] = (cnt < duty[i]) ^ ACTIVE_LOW;
  end
`ifdef LED_UART_ACK_EN
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [9:0] tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_idx;
  logic tx_busy;
  always_ff @(posedge clk_12p0 or posedge rst) begin
    if (rst) begin
      tx_sh <= '1;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_busy <= 1'b0;
    end else if (!tx_busy) begin
      if (err_event || state == COMMIT) begin
        tx_sh <= {1'b1, err_event ? NAK : ACK, 1'b0};
        tx_busy <= 1'b1;
        tx_cnt <= '0;
        tx_idx <= '0;
      end
    end else if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
      tx_cnt <= '0;
      tx_sh <= {1'b1, tx_sh[9:1]};
      tx_idx <= tx_idx + 4'd1;
      tx_busy <= tx_idx != 4'd9;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
  assign uart_tx = tx_sh[0];
`else
  assign uart_tx = 1'b1;
`endif
endmodule

// File: tb/tb_led_uart_ctrl.sv
// tb_led_uart_ctrl: randomized frame-level checks of led_uart_ctrl against a frame/PWM reference model
module tb_led_uart_ctrl;
  localparam int NUM_CH = 3;
  localparam int PWM_W = 8;
  localparam int CPB = 16;
  localparam bit AL = 1'b1;
  localparam int PER = 1 << PWM_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;
  logic [NUM_CH-1:0] led;
  logic [7:0] err_cnt;
  int ncmp = 0;
  int nfail = 0;
  int mcnt = 0;
  int merr = 0;
  int mch = 0;
  int msh [NUM_CH];
  int mact [NUM_CH];
  bit mwait = 1'b0;
  bit mall = 1'b0;
  bit err_stable = 1'b1;
  byte unsigned exp_q[$];
  int rxing = 0;
  int dc = 0;
  logic [7:0] rsh = '0;

  led_uart_ctrl #(.NUM_CH(NUM_CH), .PWM_W(PWM_W), .CLKS_PER_BIT(CPB), .ACTIVE_LOW(AL)) dut (
    .clk_12p0(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .led(led),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: advance the PWM model at the edge, then compare all outputs half a cycle later
  task automatic tick();
    logic [NUM_CH-1:0] e;
    int k;
    @(posedge clk);
    if (rst) begin
      mcnt = 0;
      foreach (mact[i]) mact[i] = 0;
    end else begin
      if (mcnt == PER - 1) mact = msh;
      mcnt = (mcnt + 1) % PER;
    end
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) e[i] = (mcnt < mact[i]) ^ AL;
      chk("led", led, e);
      if (err_stable) chk("err_cnt", err_cnt, merr);
`ifdef LED_UART_ACK_EN
      if (rxing == 0) begin
        if (uart_tx == 1'b0) begin
          rxing = 1;
          dc = 0;
        end
      end else begin
        dc++;
        k = dc / CPB;
        if (dc % CPB == CPB / 2 && k >= 1 && k <= 8) rsh = {uart_tx, rsh[7:1]};
        else if (dc % CPB == CPB / 2 && k == 9) begin
          rxing = 0;
          chk("tx_stop", uart_tx, 1);
          if (exp_q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL tx_reply: got %02h, expected no reply", rsh);
          end else chk("tx_reply", rsh, exp_q.pop_front());
        end
      end
`else
      k = 0;
      chk("uart_tx_idle", uart_tx, 1'b1);
`endif
    end
  endtask

  task automatic err_inc();
    merr = merr == 255 ? 255 : merr + 1;
    exp_q.push_back(8'h15);
  endtask

  // frame-level interpretation of one received byte
  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      err_inc();
      mwait = 1'b0;
    end else if (mwait) begin
      mwait = 1'b0;
      for (int i = 0; i < NUM_CH; i++) if (mall || i == mch) msh[i] = int'(b >> (8 - PWM_W));
      exp_q.push_back(8'h06);
    end else if (b[7:4] == 4'hA && int'(b[3:0]) < NUM_CH) begin
      mwait = 1'b1;
      mall = 1'b0;
      mch = int'(b[3:0]);
    end else if (b[7:4] == 4'hB) begin
      mwait = 1'b1;
      mall = 1'b1;
    end else err_inc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    foreach (msh[i]) msh[i] = 0;
    merr = 0;
    mwait = 1'b0;
    exp_q.delete();
    rxing = 0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // bytes start at PWM count 16 so the commit never straddles a period wrap
  task automatic align();
    for (int k = 0; k < 2 * PER && mcnt != 16; k++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    align();
    err_stable = 1'b0;
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CPB) tick();
    end
    uart_rx = stop;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    model_byte(b, stop);
    err_stable = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d);
    send_byte(c, 1'b1);
    send_byte(d, 1'b1);
  endtask

  task automatic idle_long();
    err_stable = 1'b0;
    repeat (32 * CPB + 1) tick();
    if (mwait) begin
      mwait = 1'b0;
      err_inc();
    end
    err_stable = 1'b1;
  endtask

  task automatic rst_mid_byte(input logic [7:0] b);
    align();
    err_stable = 1'b0;
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 4; k++) begin
      uart_rx = b[k];
      repeat (CPB) tick();
    end
    do_reset();
    repeat (12 * CPB) tick();
    err_stable = 1'b1;
  endtask

  task automatic count_lit(input int ch, output int n);
    n = 0;
    for (int k = 0; k < PER && mcnt != 0; k++) tick();
    for (int k = 0; k < PER; k++) begin
      n += int'(led[ch] != AL);
      tick();
    end
  endtask

  initial begin
    int n;
    logic [7:0] c;
    do_reset();
    repeat (1000) tick();
    chk("reset_led", led, 3'b111);
    chk("reset_tx", uart_tx, 1'b1);
    chk("reset_err", err_cnt, 8'd0);

    send_frame(8'hA1, 8'h80);
    count_lit(1, n);
    chk("ch1_duty_80", n, 128);
    count_lit(0, n);
    chk("ch0_off", n, 0);
    count_lit(2, n);
    chk("ch2_off", n, 0);

    send_frame(8'hB0, 8'hFF);
    for (int i = 0; i < NUM_CH; i++) begin
      count_lit(i, n);
      chk("all_duty_ff", n, 255);
    end
    send_frame(8'hB0, 8'h00);
    count_lit(0, n);
    chk("all_duty_00", n, 0);

    do_reset();
    send_frame(8'hA0, 8'h40);
    send_byte(8'hA5, 1'b1);
    chk("bad_ch_err", err_cnt, 8'd1);
    send_byte(8'hC0, 1'b1);
    chk("bad_op_err", err_cnt, 8'd2);
    count_lit(0, n);
    chk("duty_kept", n, 64);

    do_reset();
    send_byte(8'hA0, 1'b1);
    idle_long();
    chk("timeout_err", err_cnt, 8'd1);
    send_byte(8'h40, 1'b1);
    chk("after_timeout_err", err_cnt, 8'd2);
    send_byte(8'h55, 1'b0);
    chk("stop_bit_err", err_cnt, 8'd3);

    send_byte(8'hA2, 1'b1);
    rst_mid_byte(8'h40);
    chk("mid_rst_err", err_cnt, 8'd0);
    send_frame(8'hA2, 8'h40);
    count_lit(2, n);
    chk("post_rst_duty", n, 64);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 7))
        0, 1: send_frame({4'hA, 4'($urandom_range(0, NUM_CH - 1))}, 8'($urandom_range(0, 255)));
        2: send_frame({4'hB, 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 255)));
        3: begin
          c = 8'($urandom_range(0, 255));
          if (c[7:4] == 4'hB || (c[7:4] == 4'hA && int'(c[3:0]) < NUM_CH)) c[7:4] = 4'hC;
          send_byte($urandom_range(0, 1) == 1 ? c : {4'hA, 4'($urandom_range(NUM_CH, 15))}, 1'b1);
        end
        4: begin
          if ($urandom_range(0, 1) == 1) send_byte({4'hA, 4'($urandom_range(0, NUM_CH - 1))}, 1'b1);
          send_byte(8'($urandom_range(0, 255)), 1'b0);
        end
        5: begin
          send_byte({4'hB, 4'($urandom_range(0, 15))}, 1'b1);
          idle_long();
        end
        6: begin
          uart_rx = 1'b0;
          repeat (3) tick();
          uart_rx = 1'b1;
          repeat (2 * CPB) tick();
        end
        default: repeat ($urandom_range(0, 64)) tick();
      endcase
    end
    repeat (12 * CPB) tick();
    chk("final_err", err_cnt, merr);
`ifdef LED_UART_ACK_EN
    chk("tx_pending", exp_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/led_uart_ctrl.md
# led_uart_ctrl

Parametrised successor to the board-level RGB/UART top for the pico2-ice fabric. It receives 8N1 UART command frames on the ICE_27 pin and drives NUM_CH PWM LED channels; with the default NUM_CH=3 these are the RGB pins ICE_39/40/41. Duty updates are glitch-free and take effect at the PWM period boundary. An optional ACK/NAK reply is sent on the ICE_25 pin.

## Interface
- NUM_CH, 3, number of PWM LED channels, 1..8
- PWM_W, 8, PWM counter/duty width, 1..8
- CLKS_PER_BIT, 104, clk_12p0 cycles per UART bit (115200 baud), ≥ 8
- ACTIVE_LOW, 1, 1 = LED pin low when lit (iCE40 RGB sink driver)

Ports:
- clk_12p0  in  1  sole clock, 12 MHz
- rst  in  1  reset, asynchronous and active-high; all state is cleared on assertion
- uart_rx  in  1  UART receive line, idle high, asynchronous to clk_12p0
- uart_tx  out  1  UART transmit line, idle high
- led  out  NUM_CH  PWM outputs, bit i = channel i
- err_cnt  out  8  saturating count of rejected bytes/frames

## Operation
- RX path: 2-FF synchroniser, then a falling-edge start detect.
  - Start bit is re-checked at CLKS_PER_BIT/2; if it is high, the block treats it as a glitch and returns to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - The stop bit must be 1. Otherwise the byte is discarded and err_cnt increments.
- Frame = two bytes, CMD then DATA.
  - CMD[7:4]=0xA: set channel CMD[3:0].
  - CMD[7:4]=0xB: set all channels (CMD[3:0] is ignored).
- Frame FSM has states IDLE, WAIT_DATA, COMMIT.
  - IDLE + valid CMD → WAIT_DATA.
  - IDLE + invalid CMD (unknown opcode, or channel ≥ NUM_CH) → error, stay in IDLE.
  - WAIT_DATA + byte → COMMIT. The byte's bits DATA[7:8-PWM_W] load the shadow duty of the target channel(s).
  - WAIT_DATA with no byte for 32·CLKS_PER_BIT cycles after the CMD stop bit → timeout error, return to IDLE.
  - COMMIT → IDLE after 1 cycle.
  - A framing error while in WAIT_DATA aborts the frame: go to IDLE, one err_cnt increment.
- Error handling: every error increments err_cnt, which saturates at 0xFF.
- PWM: a single free-running PWM_W-bit counter shared by all channels, wrapping from 2^PWM_W−1 to 0.
  - Channel i is lit while cnt < duty[i].
  - Active duty loads from shadow duty when the counter wraps to 0.
  - duty 0 = always off. duty 2^PWM_W−1 = lit for all but one cycle per period.
  - led = lit XOR ACTIVE_LOW.
- A new frame arriving before the wrap overwrites the shadow duty; the last value written wins.

## Timing
- Reset values:
  - uart_tx=1, err_cnt=0.
  - All shadow and active duties are 0, so led = {NUM_CH{ACTIVE_LOW}} (all off).
  - PWM counter=0, FSM=IDLE.
- The RX byte-valid pulse is 1 cycle wide, in the cycle after the stop-bit sample.
- Shadow duty updates in COMMIT, 1 cycle after DATA is valid.
- Active duty changes at the next counter wrap, at most 2^PWM_W cycles later.
- err_cnt updates 1 cycle after the error event.
- rst asserted mid-byte or mid-frame: the partial frame is lost. No ACK/NAK is sent after release.
- Timeout and byte-valid in the same cycle: the byte wins and the frame completes.

## Configuration
- LED_UART_ACK_EN defined:
  - The TX serialiser (8N1, CLKS_PER_BIT) sends 0x06 after each COMMIT and 0x15 after each error.
  - uart_tx falls (start bit) 1 cycle after COMMIT or the error event.
  - A reply requested while TX is busy is dropped. Any TX drop is a protocol violation by the host.
- LED_UART_ACK_EN undefined: no TX logic is built, and uart_tx is tied to 1.

## Structure
- Package led_uart_pkg holds:
  - Opcode constants OP_SET_CH=4'hA and OP_SET_ALL=4'hB.
  - ACK=8'h06 and NAK=8'h15.
  - The frame FSM state enum.
  - TIMEOUT_BITS=32.
- Sub-module uart_rx_byte covers synchroniser, bit timing and framing check. Its outputs are byte, valid and frame_err.
- The TX serialiser, PWM and FSM stay inline in led_uart_ctrl.

## Test plan
- Reset only, 1000 cycles → led=3'b111, uart_tx=1, err_cnt=0.
- Frame 0xA1,0x80 with PWM_W=8 → after the next wrap, led[1] is low for 128 of every 256 cycles and the other channels stay high. With ACK_EN, 0x06 is received on uart_tx.
- Frame 0xB0,0xFF → all channels lit 255/256 cycles. Then send 0xB0,0x00 mid-period → the old duty holds until the wrap, then all channels are off.
- CMD 0xA5 with NUM_CH=3, then 0xC0 → err_cnt=2, duties unchanged. With ACK_EN, two 0x15 replies.
- CMD 0xA0, then idle for 32·CLKS_PER_BIT+1 cycles, then 0x40 → timeout error (err_cnt=1). The 0x40 is then parsed as an invalid CMD (err_cnt=2).
- Byte with stop bit forced 0 → err_cnt +1, FSM in IDLE. Assert rst during a DATA byte → after release, the next valid frame works and no stale reply appears.
